// File: rtl/buf_arb_pkg.sv
// buf_arb_pkg: shared grant-state encodings and sizing helper for buf_arbiter
//   FREE/LOCK0/LOCK1 : grant FSM state constants (2-bit, legacy encoding)
//   cnt_w(depth)     : width of an occupancy counter able to hold 0..depth
package buf_arb_pkg;
    localparam logic [1:0] FREE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/buf_arb_if.sv
// buf_arb_if: producer push handshakes and consumer pop port of buf_arbiter
//   p0_*/p1_* : valid/data/last offered by a producer, ready returned by the arbiter
//   c_req     : consumer pop request; c_valid/c_data: popped word one cycle later
//   master    : producer/consumer side; slave: arbiter side
interface buf_arb_if #(parameter int WIDTH = 32);
    logic             p0_valid;
    logic [WIDTH-1:0] p0_data;
    logic             p0_last;
    logic             p0_ready;
    logic             p1_valid;
    logic [WIDTH-1:0] p1_data;
    logic             p1_last;
    logic             p1_ready;
    logic             c_req;
    logic             c_valid;
    logic [WIDTH-1:0] c_data;

    modport master (
        output p0_valid, p0_data, p0_last, p1_valid, p1_data, p1_last, c_req,
        input  p0_ready, p1_ready, c_valid, c_data
    );
    modport slave (
        input  p0_valid, p0_data, p0_last, p1_valid, p1_data, p1_last, c_req,
        output p0_ready, p1_ready, c_valid, c_data
    );
endinterface

// File: rtl/buf_arb_mem.sv
// buf_arb_mem: DEPTH x WIDTH simple dual-port RAM, synchronous write, registered read
//   clock, reset        : clock; sync active-high reset clears only the read register
//   we/waddr/wdata      : write port
//   re/raddr/rdata      : read port; rdata updates the cycle after re and holds otherwise
module buf_arb_mem #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset)   rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/buf_arbiter.sv
// buf_arbiter: two-producer, one-consumer circular word buffer with message-locked grant
//   clock, reset      : clock; sync active-high reset (contents are not cleared)
//   bus (slave)       : producer push handshakes and consumer pop port
//   count/empty/full  : occupancy and its derived flags
// Define BUF_ARB_FIXED_PRIO_EN to make p0 always win in FREE instead of round-robin.
module buf_arbiter
    import buf_arb_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    buf_arb_if.slave                 bus,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [1:0]       state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             g0;
    logic             g1;
    logic             push0;
    logic             push1;
    logic             push;
    logic             pop;
    logic             last;
    logic [WIDTH-1:0] wdata;

    // A producer's grant never looks at its own valid, only at the other one's,
    // so in FREE the unfavoured side is still granted when the favoured one is idle.
`ifdef BUF_ARB_FIXED_PRIO_EN
    assign g0 = state == LOCK0 || state == FREE;
    assign g1 = state == LOCK1 || (state == FREE && !bus.p0_valid);
`else
    logic rr;
    assign g0 = state == LOCK0 || (state == FREE && (!rr || !bus.p1_valid));
    assign g1 = state == LOCK1 || (state == FREE && (rr || !bus.p0_valid));
    // rr = 1 favours p1: set whenever p0 was the last producer to transfer
    always_ff @(posedge clock) begin
        if (reset)     rr <= 1'b0;
        else if (push) rr <= push0;
    end
`endif

    assign bus.p0_ready = g0 && !full && !reset;
    assign bus.p1_ready = g1 && !full && !reset;
    assign push0 = bus.p0_valid && bus.p0_ready;
    assign push1 = bus.p1_valid && bus.p1_ready;
    assign push  = push0 || push1;
    assign wdata = push1 ? bus.p1_data : bus.p0_data;
    assign last  = push1 ? bus.p1_last : bus.p0_last;
    assign pop   = bus.c_req && !empty;
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= FREE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.c_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) count <= push ? count + 1'b1 : count - 1'b1;
            bus.c_valid <= pop;
            // only the locked producer can push in LOCKn, so any last word frees the grant
            if (push) state <= last ? FREE : (state != FREE ? state : (push1 ? LOCK1 : LOCK0));
        end
    end

    buf_arb_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clock (clock),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (bus.c_data)
    );
endmodule

// File: tb/tb_buf_arbiter.sv
// tb_buf_arbiter: directed self-checking bench for buf_arbiter on a DEPTH=4 instance
module tb_buf_arbiter;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] count;
    logic       empty;
    logic       full;
    int         tests = 0;
    int         failed = 0;
    logic [WIDTH-1:0] exp2 [4];
    logic [WIDTH-1:0] exp3 [4];

    buf_arb_if #(.WIDTH(WIDTH)) bus ();

    buf_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.p0_valid = 0; bus.p0_data = 0; bus.p0_last = 0;
        bus.p1_valid = 0; bus.p1_data = 0; bus.p1_last = 0;
        bus.c_req = 0;
`ifdef BUF_ARB_FIXED_PRIO_EN
        exp2 = '{32'h100, 32'h101, 32'h102, 32'h103};
`else
        exp2 = '{32'h100, 32'h201, 32'h102, 32'h203};
`endif
        exp3 = '{32'h50, 32'h51, 32'h52, 32'h300};
        step();
        step();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_c_valid", 32'(bus.c_valid), 0);
        chk("rst_c_data", bus.c_data, 0);
        chk("rst_p0_ready", 32'(bus.p0_ready), 0);
        reset = 0;
        #1;
        chk("post_rst_p0_ready", 32'(bus.p0_ready), 1);

        // two-word message from p0, then pop both
        bus.p0_valid = 1; bus.p0_data = 32'hA; bus.p0_last = 0;
        step();
        bus.p0_data = 32'hB; bus.p0_last = 1;
        step();
        bus.p0_valid = 0;
        chk("t1_count", 32'(count), 2);
        bus.c_req = 1;
        step();
        chk("t1_cv0", 32'(bus.c_valid), 1);
        chk("t1_cd0", bus.c_data, 32'hA);
        step();
        bus.c_req = 0;
        chk("t1_cv1", 32'(bus.c_valid), 1);
        chk("t1_cd1", bus.c_data, 32'hB);
        chk("t1_count_end", 32'(count), 0);
        chk("t1_empty", 32'(empty), 1);

        // both producers valid, single-word messages, fill to full
        do_reset();
        bus.p0_valid = 1; bus.p0_last = 1;
        bus.p1_valid = 1; bus.p1_last = 1;
        for (int i = 0; i < 4; i++) begin
            bus.p0_data = 32'h100 + i;
            bus.p1_data = 32'h200 + i;
            #1;
`ifdef BUF_ARB_FIXED_PRIO_EN
            chk("t2_p0_ready", 32'(bus.p0_ready), 1);
            chk("t2_p1_ready", 32'(bus.p1_ready), 0);
`else
            chk("t2_p0_ready", 32'(bus.p0_ready), (i % 2 == 0) ? 1 : 0);
            chk("t2_p1_ready", 32'(bus.p1_ready), (i % 2 == 1) ? 1 : 0);
`endif
            step();
        end
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 4);
        chk("t2_full_p0_ready", 32'(bus.p0_ready), 0);
        chk("t2_full_p1_ready", 32'(bus.p1_ready), 0);
        bus.c_req = 1;
        step();
        chk("t2_pushpop_count", 32'(count), 3);
        chk("t2_cv0", 32'(bus.c_valid), 1);
        chk("t2_cd0", bus.c_data, exp2[0]);
        bus.p0_valid = 0; bus.p1_valid = 0;
        for (int i = 1; i < 4; i++) begin
            step();
            chk("t2_cd", bus.c_data, exp2[i]);
        end
        bus.c_req = 0;
        chk("t2_empty", 32'(empty), 1);

        // p0 three-word message while p1 waits
        bus.p1_valid = 1; bus.p1_data = 32'h300; bus.p1_last = 1;
        bus.p0_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.p0_data = 32'h50 + i;
            bus.p0_last = (i == 2);
            #1;
            chk("t3_p0_ready", 32'(bus.p0_ready), 1);
            chk("t3_p1_ready", 32'(bus.p1_ready), 0);
            step();
        end
        bus.p0_valid = 0;
        #1;
        chk("t3_p1_ready_after", 32'(bus.p1_ready), 1);
        step();
        bus.p1_valid = 0;
        chk("t3_count", 32'(count), 4);
        bus.c_req = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_cd", bus.c_data, exp3[i]);
        end
        bus.c_req = 0;

        // streaming push+pop every cycle, pointers wrap
        bus.p0_valid = 1; bus.p0_last = 1; bus.p0_data = 32'h600;
        step();
        for (int i = 0; i < 10; i++) begin
            bus.p0_data = 32'h601 + i;
            bus.c_req = 1;
            step();
            chk("t4_cd", bus.c_data, 32'h600 + i);
            chk("t4_count", 32'(count), 1);
        end
        bus.p0_valid = 0;
        step();
        bus.c_req = 0;
        chk("t4_cd_last", bus.c_data, 32'h60A);
        chk("t4_count_end", 32'(count), 0);

        // pop while empty
        bus.c_req = 1;
        step();
        bus.c_req = 0;
        chk("t5_cv", 32'(bus.c_valid), 0);
        chk("t5_cd_hold", bus.c_data, 32'h60A);

        // reset in the middle of a p1 message
        bus.p1_valid = 1; bus.p1_last = 0; bus.p1_data = 32'h700;
        step();
        bus.p1_valid = 0; bus.p0_valid = 1;
        #1;
        chk("t6_lock_p0_ready", 32'(bus.p0_ready), 0);
        chk("t6_count", 32'(count), 1);
        reset = 1;
        step();
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_empty", 32'(empty), 1);
        chk("t6_rst_p1_ready", 32'(bus.p1_ready), 0);
        reset = 0;
        bus.p1_valid = 1;
        #1;
        chk("t6_free_p0_ready", 32'(bus.p0_ready), 1);
        chk("t6_free_p1_ready", 32'(bus.p1_ready), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
